// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even/odd parity, one stop bit.
// Each bit is majority-voted from three samples taken around its midpoint.
module uart_rx #(
    parameter int PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic       par_typ,
    output logic [7:0] p_data,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err
);

    localparam int CW = $clog2(PRESCALE);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t SAMP_A = cnt_t'(PRESCALE / 2 - 1);
    localparam cnt_t SAMP_B = cnt_t'(PRESCALE / 2);
    localparam cnt_t SAMP_C = cnt_t'(PRESCALE / 2 + 1);
    localparam cnt_t LAST   = cnt_t'(PRESCALE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state;
    cnt_t       bit_cnt;
    logic [2:0] data_idx;
    logic [7:0] shift_reg;
    logic [1:0] early_samples;
    logic       par_bit;
    logic       stop_bit;
    logic       par_en_lat;
    logic       par_typ_lat;
    logic       bit_value;
    logic       frame_par_err;
    logic       frame_stp_err;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Third sample is the live line value; the first two were captured earlier.
    assign bit_value     = maj3(early_samples[0], early_samples[1], rx_in);
    assign frame_par_err = par_en_lat & ((^shift_reg ^ par_bit) != par_typ_lat);
    assign frame_stp_err = ~stop_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            data_idx      <= '0;
            shift_reg     <= '0;
            early_samples <= '0;
            par_bit       <= 1'b0;
            stop_bit      <= 1'b0;
            par_en_lat    <= 1'b0;
            par_typ_lat   <= 1'b0;
            p_data        <= 8'h00;
            data_valid    <= 1'b0;
            par_err       <= 1'b0;
            stp_err       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            if (state != IDLE) begin
                bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + cnt_t'(1);
                if (bit_cnt == SAMP_A) early_samples[0] <= rx_in;
                if (bit_cnt == SAMP_B) early_samples[1] <= rx_in;
            end

            case (state)
                IDLE: begin
                    // The detecting cycle is edge 0 of the start bit.
                    if (!rx_in) begin
                        state       <= START;
                        bit_cnt     <= cnt_t'(1);
                        data_idx    <= '0;
                        par_en_lat  <= par_en;
                        par_typ_lat <= par_typ;
                    end
                end

                START: begin
                    if (bit_cnt == SAMP_C && bit_value) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (bit_cnt == LAST) begin
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (bit_cnt == SAMP_C)
                        shift_reg <= {bit_value, shift_reg[7:1]};
                    if (bit_cnt == LAST) begin
                        data_idx <= data_idx + 3'd1;
                        if (data_idx == 3'd7)
                            state <= par_en_lat ? PARITY : STOP;
                    end
                end

                PARITY: begin
                    if (bit_cnt == SAMP_C) par_bit <= bit_value;
                    if (bit_cnt == LAST) state <= STOP;
                end

                STOP: begin
                    if (bit_cnt == SAMP_C) stop_bit <= bit_value;
                    if (bit_cnt == LAST) begin
                        state <= IDLE;
                        if (!frame_par_err && !frame_stp_err) begin
                            data_valid <= 1'b1;
                            p_data     <= shift_reg;
                        end else begin
                            par_err <= frame_par_err;
                            stp_err <= frame_stp_err;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at PRESCALE=8: good frames, parity/stop errors,
// start glitch, back-to-back frames and mid-frame reset.
module tb_uart_rx;

    localparam int PRESCALE = 8;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    int start_cyc = 0;

    int         dv_count, pe_count, se_count;
    int         dv_abs [4];
    logic [7:0] dv_val [4];
    int         pe_abs, se_abs;

    uart_rx #(.PRESCALE(PRESCALE)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt++;

    // At a negedge, cyc_cnt equals the index of the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (data_valid) begin
                if (dv_count < 4) begin
                    dv_abs[dv_count] = cyc_cnt;
                    dv_val[dv_count] = p_data;
                end
                dv_count++;
            end
            if (par_err) begin
                pe_abs = cyc_cnt;
                pe_count++;
            end
            if (stp_err) begin
                se_abs = cyc_cnt;
                se_count++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic clear_mon();
        dv_count = 0;
        pe_count = 0;
        se_count = 0;
        pe_abs   = 0;
        se_abs   = 0;
        for (int i = 0; i < 4; i++) begin
            dv_abs[i] = 0;
            dv_val[i] = 8'h00;
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input logic v);
        rx_in = v;
        repeat (PRESCALE) @(posedge clk);
        #1;
    endtask

    // Must be entered 1 time unit after a rising edge; returns likewise.
    task automatic send_frame(input logic [7:0] b, input logic with_par,
                              input logic pbit, input logic sbit);
        rx_in = 1'b0;
        start_cyc = cyc_cnt;
        repeat (PRESCALE) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        if (with_par) hold_bit(pbit);
        hold_bit(sbit);
        rx_in = 1'b1;
    endtask

    int   s1;
    logic [7:0] partial;

    initial begin
        rst = 1'b0;
        rx_in = 1'b1;
        par_en = 1'b0;
        par_typ = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset p_data", p_data, 8'h00);
        check("reset data_valid", data_valid, 0);
        check("reset par_err", par_err, 0);
        check("reset stp_err", stp_err, 0);
        rst = 1'b1;
        idle(5);

        // 0xA5, no parity
        clear_mon();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(4);
        check("a5 dv count", dv_count, 1);
        check("a5 dv cycle", dv_abs[0] - start_cyc, 80);
        check("a5 p_data", dv_val[0], 8'hA5);
        check("a5 par_err", pe_count, 0);
        check("a5 stp_err", se_count, 0);

        // 0x3C, even parity, correct parity bit
        par_en = 1'b1;
        par_typ = 1'b0;
        clear_mon();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("3c even dv count", dv_count, 1);
        check("3c even dv cycle", dv_abs[0] - start_cyc, 88);
        check("3c even p_data", dv_val[0], 8'h3C);
        check("3c even par_err", pe_count, 0);

        // 0x3C, even parity, wrong parity bit
        clear_mon();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        idle(4);
        check("3c bad par_err count", pe_count, 1);
        check("3c bad par_err cycle", pe_abs - start_cyc, 88);
        check("3c bad dv count", dv_count, 0);
        check("3c bad stp_err", se_count, 0);
        check("3c bad p_data held", p_data, 8'h3C);

        // Odd parity; inputs changed mid-frame must not affect it
        p_data_dummy: begin end
        par_en = 1'b1;
        par_typ = 1'b1;
        clear_mon();
        fork
            send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
            begin
                repeat (20) @(posedge clk);
                #2;
                par_en = 1'b0;
                par_typ = 1'b0;
            end
        join
        idle(4);
        check("odd latch dv count", dv_count, 1);
        check("odd latch dv cycle", dv_abs[0] - start_cyc, 88);
        check("odd latch par_err", pe_count, 0);
        check("odd latch stp_err", se_count, 0);
        par_en = 1'b0;

        // Start glitch: two low cycles
        clear_mon();
        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(20);
        check("glitch dv count", dv_count, 0);
        check("glitch par_err", pe_count, 0);
        check("glitch stp_err", se_count, 0);
        check("glitch p_data held", p_data, 8'h3C);

        // Stop error then good frame
        clear_mon();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        idle(4);
        check("5a stp_err count", se_count, 1);
        check("5a stp_err cycle", se_abs - start_cyc, 80);
        check("5a dv count", dv_count, 0);
        check("5a p_data held", p_data, 8'h3C);
        clear_mon();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(4);
        check("81 dv count", dv_count, 1);
        check("81 p_data", dv_val[0], 8'h81);

        // Back-to-back frames
        clear_mon();
        s1 = cyc_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        idle(4);
        check("b2b dv count", dv_count, 2);
        check("b2b first cycle", dv_abs[0] - s1, 80);
        check("b2b spacing", dv_abs[1] - dv_abs[0], 80);
        check("b2b first value", dv_val[0], 8'h11);
        check("b2b second value", dv_val[1], 8'h22);

        // Reset during data bit 4
        clear_mon();
        partial = 8'hC3;
        rx_in = 1'b0;
        repeat (PRESCALE) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) hold_bit(partial[i]);
        rx_in = partial[4];
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst p_data", p_data, 8'h00);
        check("midrst data_valid", data_valid, 0);
        check("midrst par_err", par_err, 0);
        check("midrst stp_err", stp_err, 0);
        rx_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(10);
        check("midrst no pulse", dv_count + pe_count + se_count, 0);
        clear_mon();
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
        idle(4);
        check("f0 dv count", dv_count, 1);
        check("f0 dv cycle", dv_abs[0] - start_cyc, 80);
        check("f0 p_data", dv_val[0], 8'hF0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
